// File: rtl/iir_pkg.sv
// Shared definitions for the time-multiplexed biquad: FSM states, tap order,
// and the accumulator width rule.
package iir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int unsigned TAP_NUM = 5;
  localparam int unsigned TAP_W   = 3;

  // Taps are walked in this order during MAC; a1/a2 are subtracted.
  localparam logic [TAP_W-1:0] TAP_B0 = 3'd0;
  localparam logic [TAP_W-1:0] TAP_B1 = 3'd1;
  localparam logic [TAP_W-1:0] TAP_B2 = 3'd2;
  localparam logic [TAP_W-1:0] TAP_A1 = 3'd3;
  localparam logic [TAP_W-1:0] TAP_A2 = 3'd4;

  // Three guard bits cover the sum of five full-scale products.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w);
    return data_w + coef_w + 3;
  endfunction

endpackage

// File: rtl/iir_mac.sv
// Shared multiplier plus accumulator for the biquad; clear zeroes the sum,
// neg subtracts the current product instead of adding it.
module iir_mac #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned ACC_W  = 35
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     en,
  input  logic                     neg,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;

  assign prod     = coef * sample;
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= neg ? (acc - prod_ext) : (acc + prod_ext);
    end
  end

endmodule

// File: rtl/iir_biquad_tdm.sv
// Direct Form I biquad shared across CH_NUM channels through one multiplier.
// Define IIR_SAT_EN to clamp the output instead of two's-complement wrapping.
module iir_biquad_tdm #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned FRAC_W = 14,
  parameter int unsigned CH_NUM = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [5*COEF_W-1:0]           coefs,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(CH_NUM):0]       in_ch,
  input  logic signed [DATA_W-1:0]      in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(CH_NUM):0]       out_ch,
  output logic signed [DATA_W-1:0]      out_data,
  output logic                          ch_err
);

  import iir_pkg::*;

  localparam int unsigned CH_W  = $clog2(CH_NUM) + 1;
  localparam int unsigned IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int unsigned ACC_W = acc_width(DATA_W, COEF_W);

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_W - 1);

  state_t                    state;
  logic [TAP_W-1:0]          tap;
  logic [5*COEF_W-1:0]       coefs_q;
  logic [CH_W-1:0]           ch_q;
  logic signed [DATA_W-1:0]  x_q;

  logic signed [DATA_W-1:0]  x1_mem [CH_NUM];
  logic signed [DATA_W-1:0]  x2_mem [CH_NUM];
  logic signed [DATA_W-1:0]  y1_mem [CH_NUM];
  logic signed [DATA_W-1:0]  y2_mem [CH_NUM];

  logic [IDX_W-1:0]          idx;
  logic                      accept;
  logic                      ch_ok;
  logic                      mac_neg;
  logic signed [COEF_W-1:0]  mac_coef;
  logic signed [DATA_W-1:0]  mac_sample;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   rnd_sum;
  logic signed [ACC_W-1:0]   rnd_shift;
  logic signed [DATA_W-1:0]  y_next;

  assign idx    = ch_q[IDX_W-1:0];
  assign ch_ok  = (in_ch < CH_W'(CH_NUM));
  assign accept = (state == IDLE) && in_valid && in_ready && ch_ok;

  // Select the coefficient/history pair for the current tap.
  always_comb begin
    mac_coef   = '0;
    mac_sample = '0;
    mac_neg    = 1'b0;
    case (tap)
      TAP_B0: begin
        mac_coef   = coefs_q[5*COEF_W-1 -: COEF_W];
        mac_sample = x_q;
      end
      TAP_B1: begin
        mac_coef   = coefs_q[4*COEF_W-1 -: COEF_W];
        mac_sample = x1_mem[idx];
      end
      TAP_B2: begin
        mac_coef   = coefs_q[3*COEF_W-1 -: COEF_W];
        mac_sample = x2_mem[idx];
      end
      TAP_A1: begin
        mac_coef   = coefs_q[2*COEF_W-1 -: COEF_W];
        mac_sample = y1_mem[idx];
        mac_neg    = 1'b1;
      end
      TAP_A2: begin
        mac_coef   = coefs_q[COEF_W-1 -: COEF_W];
        mac_sample = y2_mem[idx];
        mac_neg    = 1'b1;
      end
      default: ;
    endcase
  end

  iir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .en     (state == MAC),
    .neg    (mac_neg),
    .coef   (mac_coef),
    .sample (mac_sample),
    .acc    (acc)
  );

  // Round half-up, then narrow to the sample width.
  assign rnd_sum   = acc + HALF;
  assign rnd_shift = rnd_sum >>> FRAC_W;

`ifdef IIR_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX =
    {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN =
    {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  always_comb begin
    y_next = rnd_shift[DATA_W-1:0];
    if (rnd_shift > Y_MAX) begin
      y_next = Y_MAX[DATA_W-1:0];
    end else if (rnd_shift < Y_MIN) begin
      y_next = Y_MIN[DATA_W-1:0];
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^rnd_shift[ACC_W-1:DATA_W];
  assign y_next    = rnd_shift[DATA_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tap       <= TAP_B0;
      coefs_q   <= '0;
      ch_q      <= '0;
      x_q       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ch_err    <= 1'b0;
      x1_mem    <= '{default: '0};
      x2_mem    <= '{default: '0};
      y1_mem    <= '{default: '0};
      y2_mem    <= '{default: '0};
    end else begin
      ch_err <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            if (ch_ok) begin
              coefs_q  <= coefs;
              ch_q     <= in_ch;
              x_q      <= in_data;
              tap      <= TAP_B0;
              in_ready <= 1'b0;
              state    <= MAC;
            end else begin
              // Out-of-range channel: consume the beat, flag it, stay idle.
              ch_err <= 1'b1;
            end
          end
        end
        MAC: begin
          tap <= TAP_W'(tap + TAP_W'(1));
          if (tap == TAP_A2) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          out_data    <= y_next;
          out_ch      <= ch_q;
          out_valid   <= 1'b1;
          x2_mem[idx] <= x1_mem[idx];
          x1_mem[idx] <= x_q;
          y2_mem[idx] <= y1_mem[idx];
          y1_mem[idx] <= y_next;
          state       <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_tdm.sv
// Directed, table-driven bench for iir_biquad_tdm (default parameters).
// Expected saturation result follows IIR_SAT_EN.
module tb_iir_biquad_tdm;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int CH_NUM = 2;
  localparam int CH_W   = $clog2(CH_NUM) + 1;

`ifdef IIR_SAT_EN
  localparam int SAT_EXP = 32767;
`else
  localparam int SAT_EXP = -20536;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [5*COEF_W-1:0]      coefs;
  logic                     in_valid;
  logic                     in_ready;
  logic [CH_W-1:0]          in_ch;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [CH_W-1:0]          out_ch;
  logic signed [DATA_W-1:0] out_data;
  logic                     ch_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int ch;
    int x;
    int y;
    int stall;
  } vec_t;

  vec_t vecs[$];

  iir_biquad_tdm #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .FRAC_W (14),
    .CH_NUM (CH_NUM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .coefs     (coefs),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .ch_err    (ch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic set_coefs(input int b0, input int b1, input int b2,
                           input int a1, input int a2);
    coefs = {16'(b0), 16'(b1), 16'(b2), 16'(a1), 16'(a2)};
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_ch     = '0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_ch_err", ch_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_rst", in_ready, 1);
  endtask

  // One full sample: handshake in, latency check, optional stall, handshake out.
  task automatic send(input int ch, input int x, input int y, input int stall,
                      input bit scramble);
    int n;
    logic [5*COEF_W-1:0] saved;
    n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid  = 1'b1;
    in_ch     = CH_W'(ch);
    in_data   = DATA_W'(x);
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    saved    = coefs;
    if (scramble) coefs = ~coefs;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, 6);
    for (int k = 0; k < stall; k++) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, y);
      check("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    check("out_data", out_data, y);
    check("out_ch", out_ch, ch);
    @(posedge clk); #1;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_rise", in_ready, 1);
    coefs = saved;
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) send(vecs[i].ch, vecs[i].x, vecs[i].y, vecs[i].stall, 1'b0);
  endtask

  task automatic load_impulse();
    vecs = '{'{0, 1000, 1000, 0}, '{0, 0, 500, 0}, '{0, 0, 250, 0},
             '{0, 0, 125, 0}, '{0, 0, 63, 0}};
  endtask

  initial begin
    int seen;
    set_coefs(0, 0, 0, 0, 0);
    do_reset();

    // Pass-through, with coefficients disturbed while the sample is in flight.
    set_coefs(16384, 0, 0, 0, 0);
    vecs = '{'{0, 1000, 1000, 0}, '{0, -2000, -2000, 0}};
    foreach (vecs[i]) send(vecs[i].ch, vecs[i].x, vecs[i].y, vecs[i].stall, i == 0);

    // First-order feedback decay.
    do_reset();
    set_coefs(16384, 0, 0, -8192, 0);
    load_impulse();
    run_vecs();

    // Output overflow: saturate or wrap.
    do_reset();
    set_coefs(24576, 0, 0, 0, 0);
    send(0, 30000, SAT_EXP, 0, 1'b0);

    // Two interleaved channels with backpressure.
    do_reset();
    set_coefs(16384, 0, 0, -8192, 0);
    vecs = '{'{0, 1000, 1000, 10}, '{1, 0, 0, 10}, '{0, 0, 500, 0},
             '{1, 0, 0, 3}, '{0, 0, 250, 0}, '{1, 0, 0, 0}, '{0, 0, 125, 0}};
    run_vecs();

    // Out-of-range channel is dropped.
    do_reset();
    set_coefs(16384, 0, 0, -8192, 0);
    in_valid = 1'b1;
    in_ch    = CH_W'(CH_NUM);
    in_data  = 16'sd5000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bad_ch_err", ch_err, 1);
    check("bad_in_ready", in_ready, 1);
    @(posedge clk); #1;
    check("bad_ch_err_pulse", ch_err, 0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("bad_no_output", seen, 0);
    send(0, 1000, 1000, 0, 1'b0);
    send(0, 0, 500, 0, 1'b0);

    // Reset while a sample is inside MAC, then history must start from zero.
    send(0, 0, 250, 0, 1'b0);
    in_valid = 1'b1;
    in_ch    = '0;
    in_data  = 16'sd7000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready_rise", in_ready, 1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("midrst_no_output", seen, 0);
    load_impulse();
    run_vecs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iir_biquad_tdm.md
IIR_BIQUAD_TDM -- requirements
Module: iir_biquad_tdm

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed sample width.
REQ-002 SHALL have parameter COEF_W, default 16: signed coefficient width.
REQ-003 SHALL have parameter FRAC_W, default 14: coefficient fraction bits, so 1.0 = 2^FRAC_W.
REQ-004 SHALL have parameter CH_NUM, default 2: independent channels, valid range 1..16.
REQ-005 SHALL have ports, one per line:
- clk, in, 1: single clock; all logic on posedge.
- rst, in, 1: reset, synchronous, active-high.
- coefs, in, 5*COEF_W: {b0,b1,b2,a1,a2}, b0 in the MSBs; shared by all channels.
- in_valid, in, 1: input sample offered.
- in_ready, out, 1: block can accept.
- in_ch, in, $clog2(CH_NUM)+1: channel index.
- in_data, in, DATA_W: input sample.
- out_valid, out, 1: result available.
- out_ready, in, 1: downstream accepts.
- out_ch, out, $clog2(CH_NUM)+1: channel of the result.
- out_data, out, DATA_W: filtered sample.
- ch_err, out, 1: one-cycle pulse when a bad channel is dropped.

Function
REQ-006 SHALL compute Direct Form I: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, with x1/x2/y1/y2 held per channel.
REQ-007 SHALL use a single shared multiplier with FSM states IDLE -> MAC (5 cycles, tap order b0,b1,b2,a1,a2) -> ROUND (1 cycle) -> OUT -> IDLE.
REQ-008 SHALL assert in_ready only in IDLE; a transfer occurs on in_valid && in_ready at a clock edge t.
REQ-009 SHALL latch coefs and in_ch at edge t; later coefs changes SHALL NOT affect the sample in flight.
REQ-010 SHALL use an accumulator ACC_W = DATA_W+COEF_W+3 bits, signed, with no overflow inside MAC.
REQ-011 SHALL compute y = (acc + 2^(FRAC_W-1)) >>> FRAC_W, arithmetic shift, rounding half-up.
REQ-012 SHALL register out_data and out_ch and assert out_valid at edge t+6.
REQ-013 SHALL update that channel's history at edge t+6: x2<=x1, x1<=x, y2<=y1, y1<=out_data.
REQ-014 SHALL hold out_valid, out_data and out_ch stable until out_valid && out_ready, then return to IDLE on that edge.
REQ-015 SHALL let in_ready rise on the cycle after the output transfer, giving a minimum sample period of 8 cycles.
REQ-016 SHALL accept a transfer with in_ch >= CH_NUM but drop it: no output, no history change, ch_err=1 for one cycle, remain in IDLE.
REQ-017 SHALL make the unused a0 implicitly 1.0; there is no a0 input.

Reset
REQ-018 SHALL, with rst high at any edge including mid-MAC or in OUT, go to IDLE with out_valid=0, out_data=0, out_ch=0, ch_err=0, in_ready=0 during reset.
REQ-019 SHALL clear all channel histories to 0 on reset.
REQ-020 SHALL set in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-021 SHALL, with macro IIR_SAT_EN defined, clamp y to [-2^(DATA_W-1), 2^(DATA_W-1)-1] before output and before storing it in history.
REQ-022 SHALL, with IIR_SAT_EN undefined, truncate y to its DATA_W LSBs (two's-complement wrap).

Structure
REQ-023 SHALL place the FSM state enum, tap index constants (TAP_B0..TAP_A2) and the ACC_W function in shared package iir_pkg.
REQ-024 SHALL implement the multiply-accumulate datapath (multiplier, accumulator, clear/negate control) as sub-module iir_mac.
REQ-025 SHALL store per-channel history in register arrays indexed by channel; no RAM macro.

Verification
REQ-026 Pass-through: b0=16384, others 0, ch0 inputs 1000,-2000 -> outputs 1000,-2000, out_ch=0, each at t+6.
REQ-027 Feedback: b0=16384, a1=-8192, impulse 1000 then zeros -> outputs 1000,500,250,125,63.
REQ-028 Saturation: b0=24576, x=30000 -> output 32767 with IIR_SAT_EN defined, -20536 without.
REQ-029 Channel isolation with backpressure: interleave ch0 impulse 1000 and ch1 constant 0 under the REQ-027 coefficients, out_ready low for 10 cycles -> ch0 decays as in REQ-027, ch1 stays 0, outputs stable while stalled, in_ready=0 while stalled.
REQ-030 Bad channel: in_ch=CH_NUM -> ch_err pulses once, no out_valid, and the next valid sample's output is unaffected.
REQ-031 Reset mid-operation: rst at t+3 -> out_valid=0, and after release an impulse reproduces the REQ-027 sequence from scratch.
